// File: rtl/xor_eval_sequencer.sv
// Test-vector sequencer and scorer wrapped around a fixed-latency XOR network.
// Buffers labelled vectors, drives one at a time, captures and scores the prediction.
module xor_eval_sequencer #(
  parameter int unsigned INPUT_WIDTH  = 2,
  parameter int unsigned OUTPUT_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned NN_LATENCY   = 1,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic [OUTPUT_WIDTH-1:0] s_label,
  input  logic                    s_last,
  output logic [INPUT_WIDTH-1:0]  nn_input_data,
  input  logic [OUTPUT_WIDTH-1:0] nn_prediction_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_prediction,
  output logic                    m_correct,
  output logic [COUNT_WIDTH-1:0]  total_count,
  output logic [COUNT_WIDTH-1:0]  correct_count,
  output logic                    done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = INPUT_WIDTH + OUTPUT_WIDTH + 1;
  localparam int unsigned WAIT_W = $clog2(NN_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESULT,
    ST_DONE
  } state_e;

  state_e                  state_q;
  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [INPUT_WIDTH-1:0]  nn_in_q;
  logic [OUTPUT_WIDTH-1:0] label_q;
  logic                    last_q;
  logic [WAIT_W-1:0]       wait_cnt_q;
  logic                    m_valid_q;
  logic [OUTPUT_WIDTH-1:0] m_pred_q;
  logic                    m_correct_q;
  logic [COUNT_WIDTH-1:0]  total_q;
  logic [COUNT_WIDTH-1:0]  correct_q;
  logic                    done_q;

  logic                    full_c;
  logic                    empty_c;
  logic                    push_c;
  logic                    pop_c;
  logic [ENT_W-1:0]        head_c;
  logic [INPUT_WIDTH-1:0]  head_data_c;
  logic [OUTPUT_WIDTH-1:0] head_label_c;
  logic                    head_last_c;
  logic                    pred_ok_c;

  // Ready comes straight from registered occupancy/state; a pop never bypasses full.
  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c = (count_q == '0);
  assign s_ready = !full_c && (state_q != ST_DONE);
  assign push_c  = s_valid && s_ready;
  assign pop_c   = (state_q == ST_IDLE) && !empty_c;

  assign head_c = mem_q[rd_ptr_q];
  assign {head_data_c, head_label_c, head_last_c} = head_c;
  assign pred_ok_c = (nn_prediction_data == label_q);

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {s_data, s_label, s_last};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      nn_in_q     <= '0;
      label_q     <= '0;
      last_q      <= 1'b0;
      wait_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_pred_q    <= '0;
      m_correct_q <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_c) begin
            nn_in_q    <= head_data_c;
            label_q    <= head_label_c;
            last_q     <= head_last_c;
            wait_cnt_q <= WAIT_W'(NN_LATENCY);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end else begin
            m_pred_q    <= nn_prediction_data;
            m_correct_q <= pred_ok_c;
            m_valid_q   <= 1'b1;
            // Score counters saturate instead of wrapping.
            if (total_q != '1) total_q <= total_q + COUNT_WIDTH'(1);
            if (pred_ok_c && (correct_q != '1)) correct_q <= correct_q + COUNT_WIDTH'(1);
            state_q     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign nn_input_data = nn_in_q;
  assign m_valid       = m_valid_q;
  assign m_prediction  = m_pred_q;
  assign m_correct     = m_correct_q;
  assign total_count   = total_q;
  assign correct_count = correct_q;
  assign done          = done_q;

endmodule

// File: tb/tb_xor_eval_sequencer.sv
// Bench for xor_eval_sequencer: scoreboarded default instance plus a
// long-latency, narrow-counter instance for latency and saturation.
module tb_xor_eval_sequencer;

  localparam int unsigned IW  = 2;
  localparam int unsigned OW  = 1;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;

  typedef struct packed {
    logic [OW-1:0] pred;
    logic          correct;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          s_valid, s_ready, s_last, m_valid, m_ready, m_correct, done;
  logic [IW-1:0] s_data, nn_in;
  logic [OW-1:0] s_label, nn_pred, m_prediction;
  logic [CW-1:0] total_count, correct_count;

  logic           s2_valid, s2_ready, s2_last, m2_valid, m2_correct, done2;
  logic [IW-1:0]  s2_data, nn_in2;
  logic [OW-1:0]  s2_label, nn_pred2, m2_prediction;
  logic [CW2-1:0] total2, correct2;
  logic [2:0]     pipe2;

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode;
  exp_t sb_q[$];
  int unsigned mdl_total, mdl_correct;

  xor_eval_sequencer u_dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_label(s_label), .s_last(s_last),
    .nn_input_data(nn_in), .nn_prediction_data(nn_pred),
    .m_valid(m_valid), .m_ready(m_ready), .m_prediction(m_prediction), .m_correct(m_correct),
    .total_count(total_count), .correct_count(correct_count), .done(done)
  );

  xor_eval_sequencer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(2), .NN_LATENCY(3), .COUNT_WIDTH(CW2)
  ) u_sat (
    .clk(clk), .reset(reset),
    .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data), .s_label(s2_label), .s_last(s2_last),
    .nn_input_data(nn_in2), .nn_prediction_data(nn_pred2),
    .m_valid(m2_valid), .m_ready(1'b1), .m_prediction(m2_prediction), .m_correct(m2_correct),
    .total_count(total2), .correct_count(correct2), .done(done2)
  );

  // XOR network models: one registered stage, and a three-stage delay line.
  always @(posedge clk) begin
    if (reset) begin
      nn_pred <= '0;
      pipe2   <= '0;
    end else begin
      nn_pred <= ref_xor(nn_in);
      pipe2   <= {pipe2[1:0], ref_xor(nn_in2)};
    end
  end
  assign nn_pred2 = pipe2[2];

  function automatic logic [OW-1:0] ref_xor(input logic [IW-1:0] d);
    return OW'($countones(d) % 2);
  endfunction

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // m_ready driver, offset from stimulus so mode changes take effect the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks held outputs while stalled and scores each result handshake.
  logic          held_vld = 1'b0;
  logic [OW-1:0] held_pred;
  logic          held_corr;
  exp_t          e_mon;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld) begin
          check("hold_m_valid", 32'(m_valid), 32'd1);
          check("hold_m_prediction", 32'(m_prediction), 32'(held_pred));
          check("hold_m_correct", 32'(m_correct), 32'(held_corr));
        end
        held_vld = 1'b0;
        if (m_valid && !m_ready) begin
          held_vld  = 1'b1;
          held_pred = m_prediction;
          held_corr = m_correct;
        end else if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got result with empty scoreboard at %0t", $time);
          end else begin
            e_mon = sb_q.pop_front();
            mdl_total++;
            if (e_mon.correct) mdl_correct++;
            check("m_prediction", 32'(m_prediction), 32'(e_mon.pred));
            check("m_correct", 32'(m_correct), 32'(e_mon.correct));
            check("total_count", 32'(total_count), sat(mdl_total, CW));
            check("correct_count", 32'(correct_count), sat(mdl_correct, CW));
          end
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic [OW-1:0] l, input logic last);
    exp_t e;
    bit   acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_label = l; s_last = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (acc) begin
      e.pred    = ref_xor(d);
      e.correct = (e.pred == l);
      sb_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %0d never accepted", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s2_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    mdl_total = 0; mdl_correct = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_prediction"}, 32'(m_prediction), 32'd0);
    check({tag, "_m_correct"}, 32'(m_correct), 32'd0);
    check({tag, "_nn_input"}, 32'(nn_in), 32'd0);
    check({tag, "_total"}, 32'(total_count), 32'd0);
    check({tag, "_correct"}, 32'(correct_count), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [OW-1:0] lbl [4];
  logic [IW-1:0] bd  [6];
  int            k, n, exp_corr;
  logic [IW-1:0] d;
  logic [OW-1:0] l;
  bit            took, acc2;

  initial begin
    reset = 1'b1; rdy_mode = 1; m_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_label = '0; s_last = 1'b0;
    s2_valid = 1'b0; s2_data = '0; s2_label = '0; s2_last = 1'b0;
    mdl_total = 0; mdl_correct = 0;
    lbl[0] = 1'b0; lbl[1] = 1'b1; lbl[2] = 1'b1; lbl[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("por");

    // Truth table with correct labels.
    for (int i = 0; i < 4; i++) send(IW'(i), lbl[i], i == 3);
    drain();
    check("tt_done", 32'(done), 32'd1);
    check("tt_s_ready", 32'(s_ready), 32'd0);
    check("tt_total", 32'(total_count), 32'd4);
    check("tt_correct", 32'(correct_count), 32'd4);

    // Truth table with inverted labels.
    do_reset();
    check_reset_state("rst1");
    for (int i = 0; i < 4; i++) send(IW'(i), ~lbl[i], i == 3);
    drain();
    check("inv_done", 32'(done), 32'd1);
    check("inv_total", 32'(total_count), 32'd4);
    check("inv_correct", 32'(correct_count), 32'd0);

    // Back-pressure: one in flight plus a full FIFO, then release.
    do_reset();
    rdy_mode = 0;
    for (int j = 0; j < 6; j++) bd[j] = IW'($urandom);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) begin
        s_valid = 1'b1; s_data = bd[k]; s_label = ref_xor(bd[k]); s_last = (k == 5);
      end else begin
        s_valid = 1'b0;
      end
      took = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (took) begin
        sb_q.push_back('{pred: ref_xor(bd[k]), correct: 1'b1});
        k++;
      end
    end
    s_valid = 1'b0;
    check("bp_accepted", 32'(k), 32'd5);
    check("bp_s_ready", 32'(s_ready), 32'd0);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_total", 32'(total_count), 32'd1);
    rdy_mode = 1;
    send(bd[5], ref_xor(bd[5]), 1'b1);
    drain();
    check("bp_total_end", 32'(total_count), 32'd6);
    check("bp_correct_end", 32'(correct_count), 32'd6);
    check("bp_done", 32'(done), 32'd1);

    // Reset while a sample waits on the network with two more buffered.
    do_reset();
    send(2'b01, 1'b1, 1'b0);
    send(2'b10, 1'b1, 1'b0);
    send(2'b11, 1'b0, 1'b0);
    check("mid_m_valid", 32'(m_valid), 32'd0);
    check("mid_nn_input", 32'(nn_in), 32'd1);
    do_reset();
    check_reset_state("rst_mid");
    repeat (6) @(posedge clk);
    #1;
    check("mid_empty_m_valid", 32'(m_valid), 32'd0);
    check("mid_empty_nn_input", 32'(nn_in), 32'd0);
    check("mid_empty_total", 32'(total_count), 32'd0);
    send(2'b10, 1'b1, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_to_valid_lat1", 32'(n), 32'd3);
    drain();
    check("mid_total_end", 32'(total_count), 32'd1);
    check("mid_done", 32'(done), 32'd1);

    // Randomised run with random labels, gaps and ready.
    do_reset();
    rdy_mode = 2;
    exp_corr = 0;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      d = IW'($urandom);
      l = OW'($urandom);
      if (l == ref_xor(d)) exp_corr++;
      send(d, l, i == 23);
    end
    rdy_mode = 1;
    drain();
    check("rnd_done", 32'(done), 32'd1);
    check("rnd_s_ready", 32'(s_ready), 32'd0);
    check("rnd_total", 32'(total_count), 32'd24);
    check("rnd_correct", 32'(correct_count), 32'(exp_corr));

    // Long network latency and saturating 2-bit counters.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = IW'($urandom);
      s2_valid = 1'b1; s2_data = d; s2_label = ref_xor(d); s2_last = (i == 4);
      acc2 = 1'b0;
      for (int t = 0; t < 50 && !acc2; t++) begin
        acc2 = s2_ready;
        @(posedge clk);
        #1;
      end
      s2_valid = 1'b0;
      check("sat_accept", 32'(acc2), 32'd1);
      n = 0;
      while (!m2_valid && n < 30) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("accept_to_valid_lat3", 32'(n), 32'd5);
      check("lat3_prediction", 32'(m2_prediction), 32'(ref_xor(d)));
      check("lat3_correct", 32'(m2_correct), 32'd1);
      check("sat_total", 32'(total2), sat(i + 1, CW2));
      check("sat_correct", 32'(correct2), sat(i + 1, CW2));
    end
    @(posedge clk);
    #1;
    check("sat_done", 32'(done2), 32'd1);
    check("sat_s_ready", 32'(s2_ready), 32'd0);
    check("sat_total_end", 32'(total2), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
